button_conditioner: RTL and testbench



---
 rtl/btn_pkg.sv | 15 +
 rtl/btn_debounce.sv | 87 ++++++++
 rtl/button_conditioner.sv | 73 +++++++
 tb/tb_button_conditioner.sv | 354 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/btn_pkg.sv
// Shared constants and helpers for the push-button conditioning front end.
// Default values correspond to a 100 MHz CLK.
package btn_pkg;

    localparam int DEF_CLK_DIV_W  = 12;
    localparam int DEF_N_BTN      = 2;
    localparam int DEF_DEB_TICKS  = 244;
    localparam int DEF_LONG_TICKS = 24414;

    // Bits needed to hold any count from 0 up to and including term.
    function automatic int cnt_width(input int term);
        return (term < 1) ? 1 : $clog2(term + 1);
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// One button channel: 2-flop synchroniser, tick-gated debounce, debounced level,
// press/release/long-press pulses and the hold counter behind the long press.
module btn_debounce
    import btn_pkg::*;
#(
    parameter int DEB_TICKS  = DEF_DEB_TICKS,
    parameter int LONG_TICKS = DEF_LONG_TICKS
) (
    input  logic CLK,
    input  logic reset,
    input  logic i_tick,
    input  logic i_btn_n,
    output logic o_pressed,
    output logic o_press_pulse,
    output logic o_release_pulse,
    output logic o_long_pulse
);

    localparam int DW = cnt_width(DEB_TICKS);
    localparam int HW = cnt_width(LONG_TICKS);

    logic          r_sync1;
    logic          r_sync2;
    logic [DW-1:0] r_deb_cnt;
    logic [HW-1:0] r_hold_cnt;
    logic          r_pressed;
    logic          r_press_pulse;
    logic          r_release_pulse;
    logic          r_long_pulse;
    logic          r_long_done;

    logic          w_sample;
    logic          w_accept;
    logic          w_pressed_next;
    logic          w_hold_full;

    assign w_sample       = ~r_sync2;
    assign w_accept       = i_tick && (w_sample != r_pressed) && (r_deb_cnt == DW'(DEB_TICKS - 1));
    assign w_pressed_next = w_accept ? w_sample : r_pressed;
    assign w_hold_full    = (r_hold_cnt == HW'(LONG_TICKS));

    always_ff @(posedge CLK) begin
        if (!reset) begin
            r_sync1         <= 1'b1;
            r_sync2         <= 1'b1;
            r_deb_cnt       <= '0;
            r_hold_cnt      <= '0;
            r_pressed       <= 1'b0;
            r_press_pulse   <= 1'b0;
            r_release_pulse <= 1'b0;
            r_long_pulse    <= 1'b0;
            r_long_done     <= 1'b0;
        end else begin
            r_sync1 <= i_btn_n;
            r_sync2 <= r_sync1;

            // Any tick that agrees with the current level restarts the count.
            if (i_tick) begin
                if ((w_sample == r_pressed) || w_accept) begin
                    r_deb_cnt <= '0;
                end else begin
                    r_deb_cnt <= r_deb_cnt + 1'b1;
                end
            end

            r_pressed       <= w_pressed_next;
            r_press_pulse   <= w_accept & w_sample;
            r_release_pulse <= w_accept & ~w_sample;

            // Hold count starts on the first tick after acceptance and saturates.
            if (!w_pressed_next) begin
                r_hold_cnt <= '0;
            end else if (i_tick && r_pressed && !w_hold_full) begin
                r_hold_cnt <= r_hold_cnt + 1'b1;
            end

            r_long_pulse <= w_hold_full & ~r_long_done;
            r_long_done  <= w_hold_full;
        end
    end

    assign o_pressed       = r_pressed;
    assign o_press_pulse   = r_press_pulse;
    assign o_release_pulse = r_release_pulse;
    assign o_long_pulse    = r_long_pulse;

endmodule

// File: rtl/button_conditioner.sv
// Push-button front end: sampling-tick prescaler, one debounce channel per
// button, and the two-button combo strobe used as the mode toggle.
module button_conditioner
    import btn_pkg::*;
#(
    parameter int CLK_DIV_W  = DEF_CLK_DIV_W,
    parameter int N_BTN      = DEF_N_BTN,
    parameter int DEB_TICKS  = DEF_DEB_TICKS,
    parameter int LONG_TICKS = DEF_LONG_TICKS
) (
    input  logic             CLK,
    input  logic             reset,
    input  logic [N_BTN-1:0] btn_n,
    output logic             tick,
    output logic [N_BTN-1:0] pressed,
    output logic [N_BTN-1:0] press_pulse,
    output logic [N_BTN-1:0] release_pulse,
    output logic [N_BTN-1:0] long_pulse,
    output logic             combo_pulse
);

    logic [CLK_DIV_W-1:0] r_div_cnt;
    logic                 r_tick;
    logic                 r_combo_armed;
    logic                 r_combo_pulse;

    logic                 w_both;
    logic                 w_none;

    always_ff @(posedge CLK) begin
        if (!reset) begin
            r_div_cnt <= '0;
            r_tick    <= 1'b0;
        end else begin
            r_div_cnt <= r_div_cnt + 1'b1;
            r_tick    <= &r_div_cnt;
        end
    end

    for (genvar g = 0; g < N_BTN; g++) begin : g_chan
        btn_debounce #(
            .DEB_TICKS  (DEB_TICKS),
            .LONG_TICKS (LONG_TICKS)
        ) u_chan (
            .CLK             (CLK),
            .reset           (reset),
            .i_tick          (r_tick),
            .i_btn_n         (btn_n[g]),
            .o_pressed       (pressed[g]),
            .o_press_pulse   (press_pulse[g]),
            .o_release_pulse (release_pulse[g]),
            .o_long_pulse    (long_pulse[g])
        );
    end

    assign w_both = pressed[0] & pressed[1];
    assign w_none = ~pressed[0] & ~pressed[1];

    // Fires once per both-held episode; only a full release of both re-arms it.
    always_ff @(posedge CLK) begin
        if (!reset) begin
            r_combo_armed <= 1'b1;
            r_combo_pulse <= 1'b0;
        end else begin
            r_combo_pulse <= r_combo_armed & w_both;
            r_combo_armed <= (r_combo_armed & ~w_both) | w_none;
        end
    end

    assign tick        = r_tick;
    assign combo_pulse = r_combo_pulse;

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner with small sim parameters: directed scenarios with
// literal expectations, then randomized bouncing, all checked against a cycle model.
module tb_button_conditioner;

    localparam int CDW         = 2;
    localparam int N_BTN       = 2;
    localparam int DEB         = 3;
    localparam int LONG        = 8;
    localparam int TICK_PERIOD = 1 << CDW;
    localparam int W           = 2 + 4 * N_BTN;

    logic             CLK;
    logic             reset;
    logic [N_BTN-1:0] btn_n;
    logic             tick;
    logic [N_BTN-1:0] pressed;
    logic [N_BTN-1:0] press_pulse;
    logic [N_BTN-1:0] release_pulse;
    logic [N_BTN-1:0] long_pulse;
    logic             combo_pulse;

    button_conditioner #(
        .CLK_DIV_W  (CDW),
        .N_BTN      (N_BTN),
        .DEB_TICKS  (DEB),
        .LONG_TICKS (LONG)
    ) dut (
        .CLK           (CLK),
        .reset         (reset),
        .btn_n         (btn_n),
        .tick          (tick),
        .pressed       (pressed),
        .press_pulse   (press_pulse),
        .release_pulse (release_pulse),
        .long_pulse    (long_pulse),
        .combo_pulse   (combo_pulse)
    );

    int n_checks = 0;
    int n_fail   = 0;
    logic [W-1:0] exp_q[$];

    // ---------------- clock / reset ----------------
    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // ---------------- behavioural model ----------------
    int               m_cyc = 0;
    int               m_k;
    logic             m_tick;
    logic [N_BTN-1:0] m_raw1;
    logic [N_BTN-1:0] m_raw2;
    logic [N_BTN-1:0] m_pressed;
    int               m_dis[N_BTN];
    int               m_hold[N_BTN];
    int               m_hold_prev[N_BTN];
    logic             m_armed;
    logic             m_both_old;

    task automatic model_step();
        logic [N_BTN-1:0] pp;
        logic [N_BTN-1:0] rp;
        logic [N_BTN-1:0] lp;
        logic             np;
        logic             s;
        logic             both_pre;
        logic             cb;
        pp = '0;
        rp = '0;
        lp = '0;
        cb = 1'b0;
        if (!reset) begin
            m_k        = 0;
            m_tick     = 1'b0;
            m_raw1     = '1;
            m_raw2     = '1;
            m_pressed  = '0;
            m_armed    = 1'b1;
            m_both_old = 1'b0;
            for (int b = 0; b < N_BTN; b++) begin
                m_dis[b]       = 0;
                m_hold[b]      = 0;
                m_hold_prev[b] = 0;
            end
        end else begin
            // combo: rising edge of "both held" while armed; re-armed by full release
            both_pre = m_pressed[0] & m_pressed[1];
            cb = both_pre && !m_both_old && m_armed;
            if (cb) m_armed = 1'b0;
            if (m_pressed[1:0] == 2'b00) m_armed = 1'b1;
            m_both_old = both_pre;
            for (int b = 0; b < N_BTN; b++) begin
                s     = ~m_raw2[b];
                lp[b] = (m_hold[b] == LONG) && (m_hold_prev[b] != LONG);
                np    = m_pressed[b];
                if (m_tick) begin
                    if (s != m_pressed[b]) begin
                        m_dis[b]++;
                        if (m_dis[b] == DEB) begin
                            np       = s;
                            m_dis[b] = 0;
                            pp[b]    = s;
                            rp[b]    = ~s;
                        end
                    end else begin
                        m_dis[b] = 0;
                    end
                end
                m_hold_prev[b] = m_hold[b];
                if (!np) m_hold[b] = 0;
                else if (m_tick && m_pressed[b] && m_hold[b] < LONG) m_hold[b]++;
                m_pressed[b] = np;
            end
            m_raw2 = m_raw1;
            m_raw1 = btn_n;
            m_k++;
            m_tick = ((m_k % TICK_PERIOD) == 0);
        end
        exp_q.push_back({m_tick, m_pressed, pp, rp, lp, cb});
        m_cyc++;
    endtask

    initial begin
        forever begin
            @(posedge CLK);
            model_step();
        end
    end

    // ---------------- scoreboard / monitor ----------------
    int n_press[N_BTN];
    int n_rel[N_BTN];
    int n_long[N_BTN];
    int n_combo = 0;
    int press_cyc[N_BTN];
    int long_cyc[N_BTN];
    int combo_cyc = 0;

    task automatic chk(input string name, input bit ok, input int act, input int req);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    initial begin
        logic [W-1:0] exp_v;
        logic [W-1:0] act_v;
        for (int b = 0; b < N_BTN; b++) begin
            n_press[b] = 0; n_rel[b] = 0; n_long[b] = 0;
            press_cyc[b] = 0; long_cyc[b] = 0;
        end
        forever begin
            @(negedge CLK);
            if (exp_q.size() > 0) begin
                exp_v = exp_q.pop_front();
                act_v = {tick, pressed, press_pulse, release_pulse, long_pulse, combo_pulse};
                n_checks++;
                if (act_v !== exp_v) begin
                    n_fail++;
                    $display("FAIL cycle_compare cyc=%0d: got %b, required %b", m_cyc, act_v, exp_v);
                end
            end
            for (int b = 0; b < N_BTN; b++) begin
                if (press_pulse[b] === 1'b1) begin n_press[b]++; press_cyc[b] = m_cyc; end
                if (release_pulse[b] === 1'b1) n_rel[b]++;
                if (long_pulse[b] === 1'b1) begin n_long[b]++; long_cyc[b] = m_cyc; end
            end
            if (combo_pulse === 1'b1) begin n_combo++; combo_cyc = m_cyc; end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic wait_ticks(input int n);
        int seen;
        int guard;
        seen  = 0;
        guard = 0;
        while (seen < n && guard < 1000) begin
            @(negedge CLK);
            guard++;
            if (m_tick) seen++;
        end
    endtask

    task automatic wait_pressed(input int b, input logic val, output int n);
        n = 0;
        while (pressed[b] !== val && n < 200) begin
            @(negedge CLK);
            n++;
        end
        chk("wait_pressed", pressed[b] === val, int'(pressed[b]), int'(val));
    endtask

    task automatic wait_until_idle(output int n);
        btn_n = '1;
        for (int b = 0; b < N_BTN; b++) wait_pressed(b, 1'b0, n);
        repeat (3) @(negedge CLK);
    endtask

    task automatic pulse_reset(input int cycles);
        reset = 1'b0;
        repeat (cycles) @(negedge CLK);
        reset = 1'b1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int n;
        int c0;
        int guard;
        bit found;
        int b;
        int dur;
        int r;

        reset = 1'b0;
        btn_n = '1;
        repeat (3) @(negedge CLK);
        reset = 1'b1;

        // 1: idle tick cadence
        n = 0; found = 0;
        while (!found && n < 20) begin @(negedge CLK); n++; if (tick) found = 1; end
        chk("first_tick_edge", n == 4, n, 4);
        n = 0; found = 0;
        while (!found && n < 20) begin @(negedge CLK); n++; if (tick) found = 1; end
        chk("tick_period", n == 4, n, 4);
        chk("idle_pressed", pressed == '0, int'(pressed), 0);
        repeat (5) @(negedge CLK);

        // 2: clean press on button 0
        btn_n[0] = 1'b0;
        n = 0;
        while (pressed[0] !== 1'b1 && n < 40) begin @(negedge CLK); n++; end
        chk("clean_press_latency_max", n <= 15, n, 15);
        chk("clean_press_latency_min", n >= 11, n, 11);
        chk("clean_press_pulse_first", press_pulse[0] === 1'b1, int'(press_pulse[0]), 1);
        @(negedge CLK);
        chk("clean_press_pulse_single", press_pulse[0] === 1'b0, int'(press_pulse[0]), 0);
        c0 = n_rel[0];
        btn_n[0] = 1'b1;
        wait_pressed(0, 1'b0, n);
        repeat (2) @(negedge CLK);
        chk("clean_release_count", n_rel[0] - c0 == 1, n_rel[0] - c0, 1);

        // 3: bounce 2 low ticks, 1 high tick, then steady low
        wait_ticks(2);
        c0 = n_press[0];
        btn_n[0] = 1'b0;
        wait_ticks(2);
        btn_n[0] = 1'b1;
        wait_ticks(1);
        chk("bounce_no_early_press", pressed[0] === 1'b0, int'(pressed[0]), 0);
        btn_n[0] = 1'b0;
        wait_ticks(2);
        chk("bounce_restart_count", pressed[0] === 1'b0, int'(pressed[0]), 0);
        wait_pressed(0, 1'b1, n);
        repeat (3) @(negedge CLK);
        chk("bounce_single_press", n_press[0] - c0 == 1, n_press[0] - c0, 1);
        wait_until_idle(n);

        // 4: long press on button 1
        c0 = n_long[1];
        btn_n[1] = 1'b0;
        wait_pressed(1, 1'b1, n);
        wait_ticks(12);
        chk("long_count", n_long[1] - c0 == 1, n_long[1] - c0, 1);
        chk("long_timing", long_cyc[1] - press_cyc[1] == LONG * TICK_PERIOD + 1,
            long_cyc[1] - press_cyc[1], LONG * TICK_PERIOD + 1);
        c0 = n_rel[1];
        btn_n[1] = 1'b1;
        wait_pressed(1, 1'b0, n);
        repeat (2) @(negedge CLK);
        chk("long_release", n_rel[1] - c0 == 1, n_rel[1] - c0, 1);
        wait_until_idle(n);

        // 5: combo
        c0 = n_combo;
        btn_n[0] = 1'b0;
        wait_pressed(0, 1'b1, n);
        wait_ticks(5);
        btn_n[1] = 1'b0;
        wait_pressed(1, 1'b1, n);
        repeat (3) @(negedge CLK);
        chk("combo_first", n_combo - c0 == 1, n_combo - c0, 1);
        chk("combo_lag", combo_cyc - press_cyc[1] == 1, combo_cyc - press_cyc[1], 1);
        btn_n[1] = 1'b1;
        wait_pressed(1, 1'b0, n);
        btn_n[1] = 1'b0;
        wait_pressed(1, 1'b1, n);
        repeat (3) @(negedge CLK);
        chk("combo_no_refire", n_combo - c0 == 1, n_combo - c0, 1);
        wait_until_idle(n);
        btn_n = '0;
        wait_pressed(0, 1'b1, n);
        wait_pressed(1, 1'b1, n);
        repeat (3) @(negedge CLK);
        chk("combo_rearmed", n_combo - c0 == 2, n_combo - c0, 2);
        wait_until_idle(n);

        // 6: reset mid-debounce, then mid-hold
        btn_n[0] = 1'b0;
        guard = 0;
        while (m_dis[0] != 2 && guard < 100) begin @(negedge CLK); guard++; end
        chk("reach_deb_cnt_2", m_dis[0] == 2, m_dis[0], 2);
        reset = 1'b0;
        @(negedge CLK);
        chk("rst_deb_outputs_zero",
            {tick, pressed, press_pulse, release_pulse, long_pulse, combo_pulse} === '0,
            int'({tick, pressed, press_pulse, release_pulse, long_pulse, combo_pulse}), 0);
        reset = 1'b1;
        n = 0;
        while (pressed[0] !== 1'b1 && n < 40) begin @(negedge CLK); n++; end
        chk("rst_full_deb_delay", n == 13, n, 13);
        guard = 0;
        while (m_hold[0] != 5 && guard < 100) begin @(negedge CLK); guard++; end
        chk("reach_hold_cnt_5", m_hold[0] == 5, m_hold[0], 5);
        reset = 1'b0;
        @(negedge CLK);
        chk("rst_hold_outputs_zero",
            {tick, pressed, press_pulse, release_pulse, long_pulse, combo_pulse} === '0,
            int'({tick, pressed, press_pulse, release_pulse, long_pulse, combo_pulse}), 0);
        reset = 1'b1;
        @(negedge CLK);
        chk("rst_release_quiet",
            {tick, pressed, press_pulse, release_pulse, long_pulse, combo_pulse} === '0,
            int'({tick, pressed, press_pulse, release_pulse, long_pulse, combo_pulse}), 0);
        wait_until_idle(n);

        // randomized bounce, holds and occasional resets
        for (int it = 0; it < 150; it++) begin
            r = int'($urandom_range(0, 19));
            if (r == 0) begin
                pulse_reset(int'($urandom_range(1, 3)));
            end else begin
                b = int'($urandom_range(0, N_BTN - 1));
                btn_n[b] = ~btn_n[b];
                if (r < 7) dur = int'($urandom_range(1, 6));
                else dur = int'($urandom_range(10, 120));
                repeat (dur) @(negedge CLK);
            end
        end
        wait_until_idle(n);
        repeat (10) @(negedge CLK);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
